// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared privilege, PMP configuration and PMP arbiter types
package ibex_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } priv_lvl_e;

    typedef enum logic [1:0] {
        PMP_ACC_EXEC  = 2'b00,
        PMP_ACC_WRITE = 2'b01,
        PMP_ACC_READ  = 2'b10
    } pmp_req_e;

    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_cfg_mode_e;

    typedef struct packed {
        logic          lock;
        pmp_cfg_mode_e mode;
        logic          exec;
        logic          write;
        logic          read;
    } pmp_cfg_t;

    typedef struct packed {
        logic rlb;
        logic mmwp;
        logic mml;
    } pmp_mseccfg_t;

    typedef enum logic {
        PMP_ARB_RUN,
        PMP_ARB_FREEZE
    } pmp_arb_state_e;

endpackage

// File: rtl/ibex_pmp.sv
// rtl/ibex_pmp.sv - PMP access checker; lowest-numbered matching region decides
module ibex_pmp
    import ibex_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumChan     = 1,
    parameter int unsigned PMPNumRegions  = 4
) (
    input  pmp_cfg_t     csr_pmp_cfg_i     [PMPNumRegions],
    input  logic [33:0]  csr_pmp_addr_i    [PMPNumRegions],
    input  pmp_mseccfg_t csr_pmp_mseccfg_i,
    input  priv_lvl_e    priv_mode_i       [PMPNumChan],
    input  logic [33:0]  pmp_req_addr_i    [PMPNumChan],
    input  pmp_req_e     pmp_req_type_i    [PMPNumChan],
    output logic         pmp_req_err_o     [PMPNumChan]
);

    // RLB only governs CSR writability, not the access check itself
    logic unused_rlb;
    assign unused_rlb = csr_pmp_mseccfg_i.rlb;

    // NAPOT: a pmpaddr bit is don't-care when every bit below it is set
    function automatic logic [33:0] napot_care(input logic [33:0] a);
        logic [33:0] care;
        logic        ones;
        care = '0;
        ones = 1'b1;
        for (int j = 2; j < 34; j++) begin
            care[j] = !ones && (j >= int'(PMPGranularity) + 2);
            ones    = ones & a[j];
        end
        return care;
    endfunction

    function automatic logic check_err(input priv_lvl_e priv, input logic [33:0] addr,
                                       input pmp_req_e acc);
        logic        matched, allow, hit, perm, is_m;
        logic [33:0] lo, care;
        matched = 1'b0;
        allow   = 1'b0;
        is_m    = (priv == PRIV_LVL_M);
        lo      = '0;
        for (int r = 0; r < int'(PMPNumRegions); r++) begin
            care = napot_care(csr_pmp_addr_i[r]);
            case (csr_pmp_cfg_i[r].mode)
                PMP_MODE_TOR:   hit = (addr >= lo) && (addr < csr_pmp_addr_i[r]);
                PMP_MODE_NA4:   hit = (addr[33:2] == csr_pmp_addr_i[r][33:2]);
                PMP_MODE_NAPOT: hit = ((addr ^ csr_pmp_addr_i[r]) & care) == '0;
                default:        hit = 1'b0;
            endcase
            case (acc)
                PMP_ACC_EXEC:  perm = csr_pmp_cfg_i[r].exec;
                PMP_ACC_WRITE: perm = csr_pmp_cfg_i[r].write;
                PMP_ACC_READ:  perm = csr_pmp_cfg_i[r].read;
                default:       perm = 1'b0;
            endcase
            if (hit && !matched) begin
                matched = 1'b1;
                if (csr_pmp_mseccfg_i.mml) begin
                    allow = perm && (csr_pmp_cfg_i[r].lock ? is_m : !is_m);
                end else begin
                    allow = perm || (is_m && !csr_pmp_cfg_i[r].lock);
                end
            end
            lo = csr_pmp_addr_i[r];
        end
        if (!matched) begin
            allow = is_m && !csr_pmp_mseccfg_i.mmwp
                    && !(csr_pmp_mseccfg_i.mml && acc == PMP_ACC_EXEC);
        end
        return !allow;
    endfunction

    always_comb begin
        for (int c = 0; c < int'(PMPNumChan); c++) begin
            pmp_req_err_o[c] = check_err(priv_mode_i[c], pmp_req_addr_i[c], pmp_req_type_i[c]);
        end
    end

endmodule

// File: rtl/ibex_pmp_arbiter.sv
// rtl/ibex_pmp_arbiter.sv - round-robin sharing of one PMP check channel, frozen across CSR writes
module ibex_pmp_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumRegions  = 4,
    parameter int unsigned NumReq         = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  pmp_cfg_t          csr_pmp_cfg_i     [PMPNumRegions],
    input  logic [33:0]       csr_pmp_addr_i    [PMPNumRegions],
    input  pmp_mseccfg_t      csr_pmp_mseccfg_i,
    input  logic              csr_pmp_wr_i,
    input  logic [NumReq-1:0] req_i,
    input  logic [33:0]       req_addr_i        [NumReq],
    input  pmp_req_e          req_type_i        [NumReq],
    input  priv_lvl_e         req_priv_i        [NumReq],
    output logic [NumReq-1:0] gnt_o,
    output logic [NumReq-1:0] rvalid_o,
    output logic              err_o,
    output logic              busy_o
);

    pmp_arb_state_e    r_state;
    pmp_arb_state_e    w_state_next;
    logic [NumReq-1:0] r_ptr;
    logic [NumReq-1:0] r_rvalid;
    logic              r_err;
    logic              w_arb_en;
    logic [NumReq-1:0] w_req_hi;
    logic [NumReq-1:0] w_gnt;
    logic [NumReq-1:0] w_ptr_next;
    logic [33:0]       w_chk_addr [1];
    pmp_req_e          w_chk_type [1];
    priv_lvl_e         w_chk_priv [1];
    logic              w_chk_err  [1];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PMP_ARB_RUN:    if (csr_pmp_wr_i)  w_state_next = PMP_ARB_FREEZE;
            PMP_ARB_FREEZE: if (!csr_pmp_wr_i) w_state_next = PMP_ARB_RUN;
            default:        w_state_next = PMP_ARB_RUN;
        endcase
    end

    // Gating on rst_ni keeps grants off for the whole reset, not just after its first edge
    assign w_arb_en = rst_ni && (r_state == PMP_ARB_RUN) && !csr_pmp_wr_i;

    // Requests at or above the pointer win first; otherwise wrap to the lowest request
    assign w_req_hi = req_i & ~(r_ptr - NumReq'(1));

    always_comb begin
        w_gnt = '0;
        if (w_arb_en) begin
            if (|w_req_hi) begin
                w_gnt = w_req_hi & (~w_req_hi + NumReq'(1));
            end else begin
                w_gnt = req_i & (~req_i + NumReq'(1));
            end
        end
    end

    assign w_ptr_next = {w_gnt[NumReq-2:0], w_gnt[NumReq-1]};

    always_comb begin
        w_chk_addr[0] = '0;
        w_chk_type[0] = PMP_ACC_READ;
        w_chk_priv[0] = PRIV_LVL_U;
        for (int i = 0; i < int'(NumReq); i++) begin
            if (w_gnt[i]) begin
                w_chk_addr[0] = req_addr_i[i];
                w_chk_type[0] = req_type_i[i];
                w_chk_priv[0] = req_priv_i[i];
            end
        end
    end

    ibex_pmp #(
        .PMPGranularity (PMPGranularity),
        .PMPNumChan     (1),
        .PMPNumRegions  (PMPNumRegions)
    ) u_pmp (
        .csr_pmp_cfg_i     (csr_pmp_cfg_i),
        .csr_pmp_addr_i    (csr_pmp_addr_i),
        .csr_pmp_mseccfg_i (csr_pmp_mseccfg_i),
        .priv_mode_i       (w_chk_priv),
        .pmp_req_addr_i    (w_chk_addr),
        .pmp_req_type_i    (w_chk_type),
        .pmp_req_err_o     (w_chk_err)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= PMP_ARB_RUN;
            r_ptr    <= NumReq'(1);
            r_rvalid <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_rvalid <= w_gnt;
            r_err    <= (|w_gnt) & w_chk_err[0];
            if (|w_gnt) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    assign gnt_o    = w_gnt;
    assign rvalid_o = r_rvalid;
    assign err_o    = r_err;
    assign busy_o   = (r_state == PMP_ARB_FREEZE);

endmodule

// File: tb/tb_ibex_pmp_arbiter.sv
// tb/tb_ibex_pmp_arbiter.sv - directed self-checking bench for ibex_pmp_arbiter
module tb_ibex_pmp_arbiter;
    import ibex_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    pmp_cfg_t     cfg      [4];
    logic [33:0]  paddr    [4];
    pmp_mseccfg_t msec;
    logic         csr_wr;

    logic [1:0]   req;
    logic [33:0]  req_addr [2];
    pmp_req_e     req_type [2];
    priv_lvl_e    req_priv [2];
    logic [1:0]   gnt, rvalid;
    logic         err, busy;

    logic [2:0]   req3;
    logic [33:0]  req3_addr [3];
    pmp_req_e     req3_type [3];
    priv_lvl_e    req3_priv [3];
    logic [2:0]   gnt3, rvalid3;
    logic         err3, busy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibex_pmp_arbiter dut (
        .clk_i (clk), .rst_ni (rst_n),
        .csr_pmp_cfg_i (cfg), .csr_pmp_addr_i (paddr), .csr_pmp_mseccfg_i (msec),
        .csr_pmp_wr_i (csr_wr),
        .req_i (req), .req_addr_i (req_addr), .req_type_i (req_type), .req_priv_i (req_priv),
        .gnt_o (gnt), .rvalid_o (rvalid), .err_o (err), .busy_o (busy)
    );

    ibex_pmp_arbiter #(.NumReq(3)) dut3 (
        .clk_i (clk), .rst_ni (rst_n),
        .csr_pmp_cfg_i (cfg), .csr_pmp_addr_i (paddr), .csr_pmp_mseccfg_i (msec),
        .csr_pmp_wr_i (csr_wr),
        .req_i (req3), .req_addr_i (req3_addr), .req_type_i (req3_type), .req_priv_i (req3_priv),
        .gnt_o (gnt3), .rvalid_o (rvalid3), .err_o (err3), .busy_o (busy3)
    );

    task automatic drive(input int idx, input pmp_req_e t, input priv_lvl_e p, input logic [33:0] a);
        req_type[idx] = t;
        req_priv[idx] = p;
        req_addr[idx] = a;
    endtask

    task automatic set_region0_r_only();
        cfg[0] = '{lock: 1'b0, mode: PMP_MODE_TOR, exec: 1'b0, write: 1'b0, read: 1'b1};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 2'b11;
        drive(0, PMP_ACC_READ, PRIV_LVL_U, 34'h800);
        drive(1, PMP_ACC_READ, PRIV_LVL_U, 34'h800);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (gnt !== 2'b00)    begin errors++; $display("FAIL rst_gnt got %b exp 00", gnt); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b exp 00", rvalid); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rst_first_gnt got %b exp 01", gnt); end
        req = 2'b00;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        @(negedge clk);
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (gnt !== exp_g[k]) begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, gnt, exp_g[k]); end
            if (k > 0) begin
                checks++; if (rvalid !== exp_g[k-1]) begin errors++; $display("FAIL rr_rvalid[%0d] got %b exp %b", k, rvalid, exp_g[k-1]); end
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL rr_err[%0d] got %b exp 0", k, err); end
            end
            @(negedge clk);
        end
        req = 2'b00;
        #1;
        checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL rr_rvalid_last got %b exp 10", rvalid); end
        checks++; if (gnt !== 2'b00)    begin errors++; $display("FAIL rr_gnt_idle got %b exp 00", gnt); end
    endtask

    task automatic test_fault();
        logic [1:0]  v_req  [6];
        int          v_idx  [6];
        pmp_req_e    v_type [6];
        priv_lvl_e   v_priv [6];
        logic [33:0] v_addr [6];
        logic        v_err  [6];
        v_req  = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
        v_idx  = '{1, 1, 0, 0, 1, 0};
        v_type = '{PMP_ACC_WRITE, PMP_ACC_READ, PMP_ACC_EXEC, PMP_ACC_WRITE, PMP_ACC_READ, PMP_ACC_READ};
        v_priv = '{PRIV_LVL_U, PRIV_LVL_U, PRIV_LVL_U, PRIV_LVL_M, PRIV_LVL_U, PRIV_LVL_M};
        v_addr = '{34'h800, 34'h800, 34'h800, 34'h800, 34'h2000, 34'h2000};
        v_err  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            checks++; if (rvalid !== 2'b00 || err !== 1'b0) begin errors++; $display("FAIL fault_idle[%0d] got rvalid %b err %b exp 00 0", k, rvalid, err); end
            req = v_req[k];
            drive(v_idx[k], v_type[k], v_priv[k], v_addr[k]);
            #1;
            checks++; if (gnt !== v_req[k]) begin errors++; $display("FAIL fault_gnt[%0d] got %b exp %b", k, gnt, v_req[k]); end
            @(negedge clk);
            req = 2'b00;
            #1;
            checks++; if (rvalid !== v_req[k]) begin errors++; $display("FAIL fault_rvalid[%0d] got %b exp %b", k, rvalid, v_req[k]); end
            checks++; if (err !== v_err[k])    begin errors++; $display("FAIL fault_err[%0d] got %b exp %b", k, err, v_err[k]); end
        end
    endtask

    task automatic test_freeze();
        @(negedge clk);
        csr_wr = 1'b1;
        req    = 2'b01;
        drive(0, PMP_ACC_READ, PRIV_LVL_U, 34'h800);
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL frz_wr_gnt got %b exp 00", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frz_wr_busy got %b exp 0", busy); end
        @(negedge clk);
        csr_wr = 1'b0;
        #1;
        checks++; if (gnt !== 2'b00)    begin errors++; $display("FAIL frz_hold_gnt got %b exp 00", gnt); end
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL frz_hold_busy got %b exp 1", busy); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL frz_hold_rvalid got %b exp 00", rvalid); end
        @(negedge clk);
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL frz_resume_gnt got %b exp 01", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frz_resume_busy got %b exp 0", busy); end
        @(negedge clk);
        req = 2'b00;
        #1;
        checks++; if (rvalid !== 2'b01 || err !== 1'b0) begin errors++; $display("FAIL frz_resp got rvalid %b err %b exp 01 0", rvalid, err); end
    endtask

    task automatic test_mid_freeze();
        @(negedge clk);
        csr_wr = 1'b1;
        req    = 2'b01;
        drive(0, PMP_ACC_READ, PRIV_LVL_U, 34'h800);
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL mfz_wr_gnt got %b exp 00", gnt); end
        @(negedge clk);
        csr_wr = 1'b0;
        cfg[0] = '{lock: 1'b0, mode: PMP_MODE_TOR, exec: 1'b1, write: 1'b0, read: 1'b0};
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL mfz_hold_gnt got %b exp 00", gnt); end
        @(negedge clk);
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL mfz_resume_gnt got %b exp 01", gnt); end
        @(negedge clk);
        req = 2'b00;
        #1;
        checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL mfz_rvalid got %b exp 01", rvalid); end
        checks++; if (err !== 1'b1)     begin errors++; $display("FAIL mfz_err got %b exp 1", err); end
        set_region0_r_only();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req = 2'b01;
        drive(0, PMP_ACC_READ, PRIV_LVL_U, 34'h800);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL b2b_gnt[%0d] got %b exp 01", k, gnt); end
            if (k > 0) begin
                checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL b2b_rvalid[%0d] got %b exp 01", k, rvalid); end
            end
            @(negedge clk);
        end
        req = 2'b00;
        #1;
        checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL b2b_rvalid_last got %b exp 01", rvalid); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        req = 2'b01;
        drive(0, PMP_ACC_WRITE, PRIV_LVL_U, 34'h800);
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL ar_gnt got %b exp 01", gnt); end
        @(posedge clk);
        #1;
        checks++; if (rvalid !== 2'b01 || err !== 1'b1) begin errors++; $display("FAIL ar_pending got rvalid %b err %b exp 01 1", rvalid, err); end
        rst_n = 1'b0;
        #1;
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL ar_rvalid got %b exp 00", rvalid); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL ar_err got %b exp 0", err); end
        checks++; if (gnt !== 2'b00)    begin errors++; $display("FAIL ar_gnt_rst got %b exp 00", gnt); end
        req = 2'b11;
        drive(0, PMP_ACC_READ, PRIV_LVL_U, 34'h800);
        drive(1, PMP_ACC_READ, PRIV_LVL_U, 34'h800);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL ar_ptr_reset got %b exp 01", gnt); end
        req = 2'b00;
    endtask

    task automatic test_wrap3();
        logic [2:0] v_req [6];
        logic [2:0] v_gnt [6];
        v_req = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b101, 3'b101};
        v_gnt = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b100, 3'b001};
        for (int i = 0; i < 3; i++) begin
            req3_type[i] = PMP_ACC_READ;
            req3_priv[i] = PRIV_LVL_U;
            req3_addr[i] = 34'h800;
        end
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            req3 = v_req[k];
            #1;
            checks++; if (gnt3 !== v_gnt[k]) begin errors++; $display("FAIL wrap3_gnt[%0d] got %b exp %b", k, gnt3, v_gnt[k]); end
            if (k > 0) begin
                checks++; if (rvalid3 !== v_gnt[k-1]) begin errors++; $display("FAIL wrap3_rvalid[%0d] got %b exp %b", k, rvalid3, v_gnt[k-1]); end
            end
            @(negedge clk);
        end
        req3 = 3'b000;
        #1;
        checks++; if (rvalid3 !== 3'b001 || err3 !== 1'b0) begin errors++; $display("FAIL wrap3_last got rvalid %b err %b exp 001 0", rvalid3, err3); end
    endtask

    initial begin
        rst_n  = 1'b0;
        csr_wr = 1'b0;
        msec   = '0;
        req    = 2'b00;
        req3   = 3'b000;
        for (int i = 0; i < 4; i++) begin
            cfg[i]   = '0;
            paddr[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            req3_addr[i] = '0;
            req3_type[i] = PMP_ACC_READ;
            req3_priv[i] = PRIV_LVL_U;
        end
        set_region0_r_only();
        paddr[0] = 34'h1000;

        test_reset();
        test_round_robin();
        test_fault();
        test_freeze();
        test_mid_freeze();
        test_back_to_back();
        test_async_reset();
        test_wrap3();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1);
    end

endmodule
